latch_id_ex_skid: RTL and testbench
===================================

LATCH_ID_EX_SKID -- requirements
Module: latch_id_ex_skid

Interface
REQ-001 Parameter OPERATOR_WIDTH, 8, operator field width.
REQ-002 Parameter CATEGORY_WIDTH, 3, category field width.
REQ-003 Parameter DATA_WIDTH, 32, width of each operand.
REQ-004 Parameter ADDRESS_WIDTH, 5, register write address width.
REQ-005 Parameter COUNTER_WIDTH, 16, stall counter width.
REQ-006 clock  input  1  sole clock; all state updates on its rising edge.
REQ-007 reset  input  1  synchronous, active-low reset: sampled low at a rising clock edge resets the block.
REQ-008 flush  input  1  synchronous pipeline flush; discards all held entries.
REQ-009 id_valid  input  1  ID stage presents an instruction.
REQ-010 id_ready  output  1  block accepts an instruction this cycle.
REQ-011 id_operator / id_category  input  OPERATOR_WIDTH / CATEGORY_WIDTH  decoded operation.
REQ-012 id_operand_a / id_operand_b  input  DATA_WIDTH each  source operands.
REQ-013 id_register_write_enable / id_register_write_address  input  1 / ADDRESS_WIDTH  writeback control.
REQ-014 ex_valid  output  1  EX-side payload is valid.
REQ-015 ex_ready  input  1  EX stage consumes the payload this cycle.
REQ-016 ex_operator, ex_category, ex_operand_a, ex_operand_b, ex_register_write_enable, ex_register_write_address  output  widths as the id_ counterparts  registered payload.
REQ-017 stall_cycles  output  COUNTER_WIDTH  saturating count of back-pressure cycles.

Function
REQ-018 Input transfer occurs on an edge where id_valid=1 and id_ready=1; output transfer occurs where ex_valid=1 and ex_ready=1.
REQ-019 Storage: one main register (drives ex_ outputs) plus one skid register; states EMPTY (none valid), ONE (main valid), FULL (main and skid valid).
REQ-020 id_ready is 1 in EMPTY and ONE, 0 in FULL and 0 while reset is low; it depends only on state and reset, never on ex_ready.
REQ-021 ex_valid is 1 in ONE and FULL, 0 in EMPTY.
REQ-022 EMPTY: input transfer -> ONE, main <= input; otherwise stay.
REQ-023 ONE: input and output -> ONE, main <= input; input only -> FULL, skid <= input; output only -> EMPTY; neither -> stay.
REQ-024 FULL: output -> ONE, main <= skid; otherwise stay with both registers unchanged.
REQ-025 Latency: an accepted instruction appears on ex_ outputs the cycle after acceptance when the block was EMPTY or draining; order of instructions is strictly preserved.
REQ-026 Whenever the block enters EMPTY, all ex_ payload outputs are driven 0, so a bubble never carries ex_register_write_enable=1.
REQ-027 Held payload is stable (bit-identical) on every cycle where ex_valid=1 and ex_ready=0.
REQ-028 flush=1 at an edge (reset high) -> EMPTY, both registers zeroed; a simultaneous input transfer is discarded, a simultaneous output transfer completes normally downstream.
REQ-029 stall_cycles increments by 1 on each edge with ex_valid=1 and ex_ready=0, holds at all-ones, and is unaffected by flush.
REQ-030 No combinational path from id_ inputs to ex_ outputs.

Reset
REQ-031 reset=0 at an edge -> EMPTY, skid and main registers 0, every ex_ output 0, ex_valid=0, stall_cycles=0; this overrides flush and any handshake in the same cycle.
REQ-032 Reset asserted mid-operation (ONE or FULL) discards both entries; first accept is possible on the first edge after reset returns high.

Verification
REQ-033 Streaming: ex_ready=1, id_valid=1 for 4 cycles with operand_a=1,2,3,4 -> ex_operand_a 1,2,3,4 on consecutive cycles, id_ready constantly 1, stall_cycles=0.
REQ-034 Back-pressure: load A=0x11 then B=0x22 with ex_ready=0 -> FULL, id_ready=0, ex_operand_a held 0x11; raise ex_ready -> 0x11 then 0x22 delivered, nothing lost or duplicated, stall_cycles=2 (one per held cycle).
REQ-035 Flush in FULL with id_valid=1 -> next cycle ex_valid=0, all ex_ outputs 0, id_ready=1, incoming instruction absent from output.
REQ-036 Bubble: single instruction with write_enable=1, address=5 consumed, no new input -> next cycle ex_register_write_enable=0, ex_register_write_address=0.
REQ-037 Saturation with COUNTER_WIDTH=4: hold ex_valid=1, ex_ready=0 for 20 cycles -> stall_cycles stops at 15.
REQ-038 Reset mid-stream: reset=0 for one edge while FULL -> ex_valid=0, stall_cycles=0, outputs 0; next instruction passes with one-cycle latency.

Source files
------------

// File: rtl/latch_id_ex_skid_if.sv
// ID/EX handshake bundle: valid/ready plus the decoded instruction payload.
// The producer side uses the master modport, the consumer side the slave modport.
interface latch_id_ex_skid_if #(
  parameter int OPERATOR_WIDTH = 8,
  parameter int CATEGORY_WIDTH = 3,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_WIDTH  = 5
);
  logic                      valid;
  logic                      ready;
  logic [OPERATOR_WIDTH-1:0] operator;
  logic [CATEGORY_WIDTH-1:0] category;
  logic [DATA_WIDTH-1:0]     operand_a;
  logic [DATA_WIDTH-1:0]     operand_b;
  logic                      register_write_enable;
  logic [ADDRESS_WIDTH-1:0]  register_write_address;

  modport master (
    output valid, operator, category, operand_a, operand_b,
           register_write_enable, register_write_address,
    input  ready
  );

  modport slave (
    input  valid, operator, category, operand_a, operand_b,
           register_write_enable, register_write_address,
    output ready
  );
endinterface

// File: rtl/latch_id_ex_skid.sv
// ID->EX pipeline latch with a one-entry skid buffer.
// id.ready depends only on occupancy and reset, so upstream never sees a
// combinational path from ex.ready; the skid entry absorbs the one
// instruction that arrives on the cycle back-pressure is first seen.
//
// state | meaning
// EMPTY | neither register valid, ex payload held at zero
// ONE   | main register valid and driving ex
// FULL  | main and skid valid, upstream stalled
module latch_id_ex_skid #(
  parameter int OPERATOR_WIDTH = 8,
  parameter int CATEGORY_WIDTH = 3,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_WIDTH  = 5,
  parameter int COUNTER_WIDTH  = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  latch_id_ex_skid_if.slave        id,
  latch_id_ex_skid_if.master       ex,
  output logic [COUNTER_WIDTH-1:0] stall_cycles
);

  localparam int PW = OPERATOR_WIDTH + CATEGORY_WIDTH + 2 * DATA_WIDTH + 1 + ADDRESS_WIDTH;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]    state;
  logic [PW-1:0] main_q;
  logic [PW-1:0] skid_q;
  logic [PW-1:0] in_word;
  logic          in_xfer;
  logic          out_xfer;

  assign in_word = {id.operator, id.category, id.operand_a, id.operand_b,
                    id.register_write_enable, id.register_write_address};

  assign {ex.operator, ex.category, ex.operand_a, ex.operand_b,
          ex.register_write_enable, ex.register_write_address} = main_q;

  assign id.ready = reset && (state != FULL);
  assign ex.valid = (state == ONE) || (state == FULL);
  assign in_xfer  = id.valid && id.ready;
  assign out_xfer = ex.valid && ex.ready;

  // Occupancy FSM and payload registers; main is zeroed whenever the block empties.
  always_ff @(posedge clock) begin
    if (!reset || flush) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            main_q <= in_word;
            state  <= ONE;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_q <= in_word;
          end else if (in_xfer) begin
            skid_q <= in_word;
            state  <= FULL;
          end else if (out_xfer) begin
            main_q <= '0;
            state  <= EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            main_q <= skid_q;
            skid_q <= '0;
            state  <= ONE;
          end
        end
        default: begin
          state  <= EMPTY;
          main_q <= '0;
          skid_q <= '0;
        end
      endcase
    end
  end

  // Saturating back-pressure counter; flush deliberately leaves it alone.
  always_ff @(posedge clock) begin
    if (!reset) begin
      stall_cycles <= '0;
    end else if (ex.valid && !ex.ready && (stall_cycles != {COUNTER_WIDTH{1'b1}})) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_latch_id_ex_skid.sv
// Directed bench for latch_id_ex_skid with hand-computed expectations.
module tb_latch_id_ex_skid;

  logic       clock;
  logic       reset;
  logic       flush;
  logic [3:0] stall_cycles;

  int total = 0;
  int bad   = 0;

  latch_id_ex_skid_if #(.OPERATOR_WIDTH(8), .CATEGORY_WIDTH(3), .DATA_WIDTH(32), .ADDRESS_WIDTH(5)) id_bus ();
  latch_id_ex_skid_if #(.OPERATOR_WIDTH(8), .CATEGORY_WIDTH(3), .DATA_WIDTH(32), .ADDRESS_WIDTH(5)) ex_bus ();

  latch_id_ex_skid #(
    .OPERATOR_WIDTH(8), .CATEGORY_WIDTH(3), .DATA_WIDTH(32),
    .ADDRESS_WIDTH(5), .COUNTER_WIDTH(4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .flush        (flush),
    .id           (id_bus),
    .ex           (ex_bus),
    .stall_cycles (stall_cycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a);
    id_bus.valid     = v;
    id_bus.operand_a = a;
  endtask

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    id_bus.valid = 1'b0;
    id_bus.operator = 8'h00;
    id_bus.category = 3'd0;
    id_bus.operand_a = 32'h0;
    id_bus.operand_b = 32'h0;
    id_bus.register_write_enable = 1'b0;
    id_bus.register_write_address = 5'd0;
    ex_bus.ready = 1'b0;

    // reset state
    tick();
    tick();
    check_eq("rst_ex_valid", 32'(ex_bus.valid), 32'd0);
    check_eq("rst_id_ready_low", 32'(id_bus.ready), 32'd0);
    check_eq("rst_stall", 32'(stall_cycles), 32'd0);
    check_eq("rst_operand_a", ex_bus.operand_a, 32'd0);
    check_eq("rst_we", 32'(ex_bus.register_write_enable), 32'd0);
    reset = 1'b1;
    tick();
    check_eq("post_rst_id_ready", 32'(id_bus.ready), 32'd1);
    check_eq("post_rst_ex_valid", 32'(ex_bus.valid), 32'd0);

    // streaming
    ex_bus.ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 32'(i));
      tick();
      check_eq("stream_a", ex_bus.operand_a, 32'(i));
      check_eq("stream_valid", 32'(ex_bus.valid), 32'd1);
      check_eq("stream_id_ready", 32'(id_bus.ready), 32'd1);
    end
    drive(1'b0, 32'h0);
    tick();
    check_eq("stream_drain_valid", 32'(ex_bus.valid), 32'd0);
    check_eq("stream_drain_a", ex_bus.operand_a, 32'd0);
    check_eq("stream_stall", 32'(stall_cycles), 32'd0);

    // back-pressure
    ex_bus.ready = 1'b0;
    drive(1'b1, 32'h11);
    tick();
    check_eq("bp_one_a", ex_bus.operand_a, 32'h11);
    drive(1'b1, 32'h22);
    tick();
    check_eq("bp_full_id_ready", 32'(id_bus.ready), 32'd0);
    check_eq("bp_full_a", ex_bus.operand_a, 32'h11);
    check_eq("bp_stall1", 32'(stall_cycles), 32'd1);
    drive(1'b0, 32'h0);
    tick();
    check_eq("bp_hold_a", ex_bus.operand_a, 32'h11);
    check_eq("bp_stall2", 32'(stall_cycles), 32'd2);
    ex_bus.ready = 1'b1;
    tick();
    check_eq("bp_second_a", ex_bus.operand_a, 32'h22);
    check_eq("bp_second_valid", 32'(ex_bus.valid), 32'd1);
    check_eq("bp_id_ready_back", 32'(id_bus.ready), 32'd1);
    tick();
    check_eq("bp_empty_valid", 32'(ex_bus.valid), 32'd0);
    check_eq("bp_stall_final", 32'(stall_cycles), 32'd2);

    // flush while full, with a simultaneous incoming instruction
    ex_bus.ready = 1'b0;
    drive(1'b1, 32'h33);
    tick();
    drive(1'b1, 32'h44);
    tick();
    check_eq("fl_full_id_ready", 32'(id_bus.ready), 32'd0);
    id_bus.operator = 8'h5A;
    drive(1'b1, 32'h55);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0);
    id_bus.operator = 8'h00;
    check_eq("fl_valid", 32'(ex_bus.valid), 32'd0);
    check_eq("fl_a", ex_bus.operand_a, 32'd0);
    check_eq("fl_operator", 32'(ex_bus.operator), 32'd0);
    check_eq("fl_id_ready", 32'(id_bus.ready), 32'd1);
    check_eq("fl_stall", 32'(stall_cycles), 32'd4);
    tick();
    check_eq("fl_dropped_valid", 32'(ex_bus.valid), 32'd0);

    // bubble after a write-enabled instruction
    ex_bus.ready = 1'b1;
    id_bus.operator = 8'hA5;
    id_bus.category = 3'd3;
    id_bus.operand_b = 32'hDEADBEEF;
    id_bus.register_write_enable = 1'b1;
    id_bus.register_write_address = 5'd5;
    drive(1'b1, 32'h66);
    tick();
    check_eq("bub_we", 32'(ex_bus.register_write_enable), 32'd1);
    check_eq("bub_addr", 32'(ex_bus.register_write_address), 32'd5);
    check_eq("bub_operator", 32'(ex_bus.operator), 32'hA5);
    check_eq("bub_category", 32'(ex_bus.category), 32'd3);
    check_eq("bub_operand_b", ex_bus.operand_b, 32'hDEADBEEF);
    id_bus.operator = 8'h00;
    id_bus.category = 3'd0;
    id_bus.operand_b = 32'h0;
    id_bus.register_write_enable = 1'b0;
    id_bus.register_write_address = 5'd0;
    drive(1'b0, 32'h0);
    tick();
    check_eq("bub_valid0", 32'(ex_bus.valid), 32'd0);
    check_eq("bub_we0", 32'(ex_bus.register_write_enable), 32'd0);
    check_eq("bub_addr0", 32'(ex_bus.register_write_address), 32'd0);
    check_eq("bub_operand_b0", ex_bus.operand_b, 32'd0);

    // saturation of the 4-bit stall counter, payload held stable
    ex_bus.ready = 1'b0;
    drive(1'b1, 32'h77);
    tick();
    drive(1'b0, 32'h0);
    check_eq("sat_start", 32'(stall_cycles), 32'd4);
    for (int i = 1; i <= 20; i++) begin
      tick();
      check_eq("sat_hold_a", ex_bus.operand_a, 32'h77);
      if (i == 10) check_eq("sat_mid", 32'(stall_cycles), 32'd14);
    end
    check_eq("sat_end", 32'(stall_cycles), 32'd15);

    // reset while full
    drive(1'b1, 32'h88);
    tick();
    check_eq("rm_full_id_ready", 32'(id_bus.ready), 32'd0);
    check_eq("rm_full_a", ex_bus.operand_a, 32'h77);
    reset = 1'b0;
    drive(1'b0, 32'h0);
    tick();
    check_eq("rm_valid", 32'(ex_bus.valid), 32'd0);
    check_eq("rm_stall", 32'(stall_cycles), 32'd0);
    check_eq("rm_a", ex_bus.operand_a, 32'd0);
    check_eq("rm_id_ready_low", 32'(id_bus.ready), 32'd0);
    reset = 1'b1;
    ex_bus.ready = 1'b1;
    drive(1'b1, 32'h99);
    tick();
    check_eq("rm_next_valid", 32'(ex_bus.valid), 32'd1);
    check_eq("rm_next_a", ex_bus.operand_a, 32'h99);
    drive(1'b0, 32'h0);
    tick();
    check_eq("rm_drain_valid", 32'(ex_bus.valid), 32'd0);
    check_eq("rm_drain_a", ex_bus.operand_a, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
